// File: rtl/mem_bus_responder.sv
// Memory responder on the 8051 external bus: program ROM plus data RAM, with
// a configurable number of wait states before read data is presented.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   addr_bus[15:0]        CPU address
//   data_in[7:0]          CPU write data
//   data_out[7:0]         registered read data
//   data_oe               registered drive enable for data_bus
//   read_en, write_en     CPU strobes (level)
//   memory_select         0 = program ROM, 1 = data RAM
//   PSEN                  program-store enable, active-low, required for ROM reads
//   rom_wr_en/addr/data   ROM preload port, honoured on every edge
//   bus_err               registered one-cycle pulse on an illegal access
module mem_bus_responder #(
    parameter int unsigned ROM_AW      = 12,
    parameter int unsigned RAM_AW      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addr_bus,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    input  logic              read_en,
    input  logic              write_en,
    input  logic              memory_select,
    input  logic              PSEN,
    input  logic              rom_wr_en,
    input  logic [ROM_AW-1:0] rom_wr_addr,
    input  logic [7:0]        rom_wr_data,
    output logic              bus_err
);

    localparam int unsigned ROM_DEPTH = 1 << ROM_AW;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2,
        S_WHOLD = 2'd3
    } state_e;

    logic [7:0] rom_mem [0:ROM_DEPTH-1];
    logic [7:0] ram_mem [0:RAM_DEPTH-1];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        msel_q, msel_d;
    logic        psen_q, psen_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic        bus_err_q, bus_err_d;

    logic [15:0] ld_addr_c;
    logic        ld_msel_c;
    logic        ld_psen_c;
    logic        rd_legal_c;
    logic [7:0]  rd_data_c;
    logic        ram_we_c;
    logic        start_rd_c;

    function automatic logic rom_legal(input logic [15:0] a, input logic ms, input logic ps);
        return !ms && !ps && ((a >> ROM_AW) == 16'd0);
    endfunction

    function automatic logic ram_legal(input logic [15:0] a, input logic ms);
        return ms && ((a >> RAM_AW) == 16'd0);
    endfunction

    // Load source: the live bus when a read is started and loaded in the same
    // cycle (zero wait states), otherwise the address latched at the start.
    always_comb begin
        ld_addr_c = (state_q == S_WAIT) ? addr_q : addr_bus;
        ld_msel_c = (state_q == S_WAIT) ? msel_q : memory_select;
        ld_psen_c = (state_q == S_WAIT) ? psen_q : PSEN;
        rd_legal_c = rom_legal(ld_addr_c, ld_msel_c, ld_psen_c) || ram_legal(ld_addr_c, ld_msel_c);
        if (!rd_legal_c) begin
            rd_data_c = 8'hFF;
        end else if (ld_msel_c) begin
            rd_data_c = ram_mem[ld_addr_c[RAM_AW-1:0]];
        end else begin
            rd_data_c = rom_mem[ld_addr_c[ROM_AW-1:0]];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        msel_d     = msel_q;
        psen_d     = psen_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        bus_err_d  = 1'b0;
        ram_we_c   = 1'b0;
        start_rd_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (read_en && write_en) begin
                    bus_err_d = 1'b1;
                end else if (read_en) begin
                    start_rd_c = 1'b1;
                end else if (write_en) begin
                    state_d = S_WHOLD;
                    if (ram_legal(addr_bus, memory_select)) begin
                        ram_we_c = !reset;
                    end else begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!read_en) begin
                    state_d   = S_IDLE;
                    data_oe_d = 1'b0;
                end else if (cnt_q <= 4'd1) begin
                    state_d    = S_DRIVE;
                    cnt_d      = 4'd0;
                    data_out_d = rd_data_c;
                    data_oe_d  = 1'b1;
                    bus_err_d  = !rd_legal_c;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DRIVE: begin
                data_oe_d = 1'b1;
                if (!read_en) begin
                    state_d   = S_IDLE;
                    data_oe_d = 1'b0;
                end else if (addr_bus != addr_q || memory_select != msel_q) begin
                    start_rd_c = 1'b1;
                end
            end
            S_WHOLD: begin
                if (!write_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Start (or restart) a read; data_oe keeps its current value until the load.
        if (start_rd_c) begin
            addr_d = addr_bus;
            msel_d = memory_select;
            psen_d = PSEN;
            if (WAIT_STATES == 0) begin
                state_d    = S_DRIVE;
                cnt_d      = 4'd0;
                data_out_d = rd_data_c;
                data_oe_d  = 1'b1;
                bus_err_d  = !rd_legal_c;
            end else begin
                state_d = S_WAIT;
                cnt_d   = 4'(WAIT_STATES);
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'h0000;
            msel_q     <= 1'b0;
            psen_q     <= 1'b1;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            msel_q     <= msel_d;
            psen_q     <= psen_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Storage arrays; contents survive reset.
    always_ff @(posedge clk) begin
        if (rom_wr_en) begin
            rom_mem[rom_wr_addr] <= rom_wr_data;
        end
        if (ram_we_c) begin
            ram_mem[addr_bus[RAM_AW-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed, table-driven bench for mem_bus_responder. A WAIT_STATES=1 instance
// runs the vector table; a WAIT_STATES=3 instance sharing the same inputs is
// used for the abort and long-latency sequences.
module tb_mem_bus_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr_bus;
    logic [7:0]  data_in;
    logic        read_en;
    logic        write_en;
    logic        memory_select;
    logic        PSEN;
    logic        rom_wr_en;
    logic [11:0] rom_wr_addr;
    logic [7:0]  rom_wr_data;

    logic [7:0]  data_out,  data_out3;
    logic        data_oe,   data_oe3;
    logic        bus_err,   bus_err3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        msel;
        logic        psen;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        oe;
        logic [7:0]  dout;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    mem_bus_responder #(.ROM_AW(12), .RAM_AW(8), .WAIT_STATES(1)) u_dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .read_en(read_en), .write_en(write_en),
        .memory_select(memory_select), .PSEN(PSEN), .rom_wr_en(rom_wr_en),
        .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data), .bus_err(bus_err)
    );

    mem_bus_responder #(.ROM_AW(12), .RAM_AW(8), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .data_in(data_in),
        .data_out(data_out3), .data_oe(data_oe3), .read_en(read_en), .write_en(write_en),
        .memory_select(memory_select), .PSEN(PSEN), .rom_wr_en(rom_wr_en),
        .rom_wr_addr(rom_wr_addr), .rom_wr_data(rom_wr_data), .bus_err(bus_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic rd, input logic wr, input logic msel, input logic psen,
                                input logic [15:0] addr, input logic [7:0] din,
                                input logic oe, input logic [7:0] dout, input logic err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.msel = msel; v.psen = psen; v.addr = addr; v.din = din;
        v.oe = oe; v.dout = dout; v.err = err;
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic msel, input logic psen,
                         input logic [15:0] addr, input logic [7:0] din);
        read_en = rd; write_en = wr; memory_select = msel; PSEN = psen;
        addr_bus = addr; data_in = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        rom_wr_en = 1'b0; rom_wr_addr = 12'h000; rom_wr_data = 8'h00;
        idle();

        // ROM preload while reset is held.
        rom_wr_en = 1'b1;
        rom_wr_addr = 12'h010; rom_wr_data = 8'hC3; tick();
        rom_wr_addr = 12'h000; rom_wr_data = 8'h82; tick();
        rom_wr_addr = 12'h001; rom_wr_data = 8'h22; tick();
        rom_wr_addr = 12'h005; rom_wr_data = 8'hA5; tick();
        rom_wr_en = 1'b0;
        tick();
        chk("reset data_out", data_out, 8'h00);
        chk("reset data_oe", 8'(data_oe), 8'h00);
        chk("reset bus_err", 8'(bus_err), 8'h00);
        chk("reset data_oe ws3", 8'(data_oe3), 8'h00);
        reset = 1'b0;

        // rd wr ms ps addr din | oe dout err  (one row per clock, WAIT_STATES=1)
        vecs.push_back(mk(1,0,0,0,16'h0010,8'h00, 0,8'h00,0));
        vecs.push_back(mk(1,0,0,0,16'h0010,8'h00, 1,8'hC3,0));
        vecs.push_back(mk(1,0,0,0,16'h0010,8'h00, 1,8'hC3,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(0,1,1,1,16'h0030,8'h50, 0,8'hC3,0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0,1,1,1,16'h0030,8'h77, 0,8'hC3,0));
        vecs.push_back(mk(0,0,1,1,16'h0030,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(1,0,1,1,16'h0030,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(1,0,1,1,16'h0030,8'h00, 1,8'h50,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'h50,0));
        vecs.push_back(mk(1,0,1,1,16'h0130,8'h00, 0,8'h50,0));
        vecs.push_back(mk(1,0,1,1,16'h0130,8'h00, 1,8'hFF,1));
        vecs.push_back(mk(1,0,1,1,16'h0130,8'h00, 1,8'hFF,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(0,1,0,1,16'h0010,8'h11, 0,8'hFF,1));
        vecs.push_back(mk(0,1,0,1,16'h0010,8'h11, 0,8'hFF,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(1,0,0,0,16'h0010,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(1,0,0,0,16'h0010,8'h00, 1,8'hC3,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(1,1,1,1,16'h0030,8'hEE, 0,8'hC3,1));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(1,0,1,1,16'h0030,8'h00, 0,8'hC3,0));
        vecs.push_back(mk(1,0,1,1,16'h0030,8'h00, 1,8'h50,0));
        vecs.push_back(mk(1,0,0,0,16'h0000,8'h00, 1,8'h50,0));
        vecs.push_back(mk(1,0,0,0,16'h0000,8'h00, 1,8'h82,0));
        vecs.push_back(mk(1,0,0,0,16'h0001,8'h00, 1,8'h82,0));
        vecs.push_back(mk(1,0,0,0,16'h0001,8'h00, 1,8'h22,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'h22,0));
        vecs.push_back(mk(1,0,0,1,16'h0005,8'h00, 0,8'h22,0));
        vecs.push_back(mk(1,0,0,1,16'h0005,8'h00, 1,8'hFF,1));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(1,0,0,0,16'h1005,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(1,0,0,0,16'h1005,8'h00, 1,8'hFF,1));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(0,1,1,1,16'h00FF,8'h3C, 0,8'hFF,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(1,0,1,1,16'h00FF,8'h00, 0,8'hFF,0));
        vecs.push_back(mk(1,0,1,1,16'h00FF,8'h00, 1,8'h3C,0));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'h3C,0));
        vecs.push_back(mk(0,1,1,1,16'h0100,8'hAA, 0,8'h3C,1));
        vecs.push_back(mk(0,0,0,1,16'h0000,8'h00, 0,8'h3C,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].msel, vecs[i].psen, vecs[i].addr, vecs[i].din);
            tick();
            chk($sformatf("row%0d data_oe", i), 8'(data_oe), 8'(vecs[i].oe));
            chk($sformatf("row%0d data_out", i), data_out, vecs[i].dout);
            chk($sformatf("row%0d bus_err", i), 8'(bus_err), 8'(vecs[i].err));
        end

        // Abort in WAIT with three wait states: never drives, data_out untouched.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h00);
        tick(); chk("abort ws3 oe e0", 8'(data_oe3), 8'h00);
        tick(); chk("abort ws3 oe e1", 8'(data_oe3), 8'h00);
        chk("abort ws1 oe e1", 8'(data_oe), 8'h01);
        idle();
        tick(); chk("abort ws3 oe e2", 8'(data_oe3), 8'h00);
        chk("abort ws3 data_out", data_out3, 8'h50);
        chk("ws1 oe falls", 8'(data_oe), 8'h00);
        tick(); chk("abort ws3 oe e3", 8'(data_oe3), 8'h00);
        chk("abort ws3 bus_err", 8'(bus_err3), 8'h00);

        // Full three-wait-state read, then reset while both instances drive.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 8'h00);
        tick(); chk("ws3 lat oe e0", 8'(data_oe3), 8'h00);
        tick(); chk("ws3 lat oe e1", 8'(data_oe3), 8'h00);
        tick(); chk("ws3 lat oe e2", 8'(data_oe3), 8'h00);
        tick(); chk("ws3 lat oe e3", 8'(data_oe3), 8'h01);
        chk("ws3 lat data", data_out3, 8'hA5);
        chk("ws1 drive data", data_out, 8'hA5);
        reset = 1'b1;
        tick();
        chk("mid reset oe", 8'(data_oe), 8'h00);
        chk("mid reset data", data_out, 8'h00);
        chk("mid reset oe ws3", 8'(data_oe3), 8'h00);
        chk("mid reset data ws3", data_out3, 8'h00);
        reset = 1'b0;
        idle();
        tick();

        // A write presented during reset must not land.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 8'h12); tick();
        idle(); tick();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 8'h99); tick();
        reset = 1'b0;
        idle(); tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 8'h00);
        tick(); tick();
        chk("reset blocks write", data_out, 8'h12);
        chk("reset blocks write oe", 8'(data_oe), 8'h01);
        idle(); tick();

        // Preload to the address being loaded returns the old byte.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h00);
        tick();
        rom_wr_en = 1'b1; rom_wr_addr = 12'h010; rom_wr_data = 8'h44;
        tick();
        rom_wr_en = 1'b0;
        chk("collision old byte", data_out, 8'hC3);
        idle(); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 8'h00);
        tick(); tick();
        chk("collision new byte", data_out, 8'h44);
        idle(); tick();
        chk("final oe", 8'(data_oe), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
